// File: rtl/step_sequencer_pkg.sv
// Shared control definitions for the instruction step sequencer.
package step_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam int unsigned STEP_W_DEF = 3;
   localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/enabled_decoder_three.sv
// Enabled 3:8 decoder producing one-hot T-states; all-zero when disabled.
module enabled_decoder_three (
   input  logic       en,
   input  logic [2:0] sel,
   output logic [7:0] y
);

   always_comb begin
      y = '0;
      if (en) y[sel] = 1'b1;
   end

endmodule

// File: rtl/step_sequencer.sv
// Instruction timing-step generator: counts 0..last_step, with single-step, restart, halt at boundary.
module step_sequencer
   import step_sequencer_pkg::*;
#(
   parameter int unsigned STEP_W = STEP_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   single_step,
   input  logic                   step_req,
   input  logic                   restart,
   input  logic                   halt,
   input  logic [STEP_W-1:0]      last_step,
   output logic [STEP_W-1:0]      step,
   output logic                   step_en,
   output logic [(2**STEP_W)-1:0] t_state,
   output logic                   instr_done,
   output logic                   halted,
   output logic [CNT_W-1:0]       instr_count
);

   localparam int unsigned NT = 2**STEP_W;

   state_t state;
   logic   halt_pending;
   logic   advance;
   logic   boundary;

   always_comb begin
      advance  = single_step ? step_req : 1'b1;
      boundary = restart | (advance & (step == last_step));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         step         <= '0;
         step_en      <= 1'b0;
         instr_done   <= 1'b0;
         halted       <= 1'b0;
         instr_count  <= '0;
         halt_pending <= 1'b0;
      end else begin
         instr_done <= 1'b0;
         unique case (state)
            IDLE: begin
               step <= '0;
               if (halt) halt_pending <= 1'b1;
               if (run) begin
                  state   <= RUN;
                  step_en <= 1'b1;
               end
            end
            RUN: begin
               if (!run) begin
                  // Abort: pending halt survives for the next run.
                  state   <= IDLE;
                  step    <= '0;
                  step_en <= 1'b0;
                  if (halt) halt_pending <= 1'b1;
               end else if (boundary) begin
                  step       <= '0;
                  instr_done <= 1'b1;
                  if (instr_count != '1) instr_count <= instr_count + 1'b1;
                  if (halt_pending || halt) begin
                     state        <= HALTED;
                     step_en      <= 1'b0;
                     halted       <= 1'b1;
                     halt_pending <= 1'b0;
                  end
               end else begin
                  if (advance) step <= step + 1'b1;
                  if (halt) halt_pending <= 1'b1;
               end
            end
            HALTED: begin
               step    <= '0;
               step_en <= 1'b0;
               halted  <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               step    <= '0;
               step_en <= 1'b0;
            end
         endcase
      end
   end

   generate
      if (STEP_W == 3) begin : g_dec3
         enabled_decoder_three u_dec (
            .en  (step_en),
            .sel (step),
            .y   (t_state)
         );
      end else begin : g_decn
         always_comb t_state = step_en ? (NT'(1) << step) : '0;
      end
   endgenerate

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_step_sequencer;

   logic       clk = 1'b0;
   logic       reset, run, single_step, step_req, restart, halt;
   logic [2:0] last_step;
   logic [2:0] step;
   logic       step_en;
   logic [7:0] t_state;
   logic       instr_done, halted;
   logic [3:0] instr_count;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      nm;
      logic [2:0] s;
      logic       en;
      logic       d;
      logic       h;
      logic [3:0] c;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   step_sequencer #(.STEP_W(3), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .single_step (single_step),
      .step_req    (step_req),
      .restart     (restart),
      .halt        (halt),
      .last_step   (last_step),
      .step        (step),
      .step_en     (step_en),
      .t_state     (t_state),
      .instr_done  (instr_done),
      .halted      (halted),
      .instr_count (instr_count)
   );

   // Monitor: outputs are registered, so one expectation is due each cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [7:0] et;
         logic [7:0] one;
         e   = q.pop_front();
         one = 8'd1;
         et  = e.en ? (one << e.s) : 8'd0;
         n_cmp++;
         if (step !== e.s || step_en !== e.en || t_state !== et || instr_done !== e.d ||
             halted !== e.h || instr_count !== e.c) begin
            n_bad++;
            $display("FAIL %s: got step=%0d en=%b t=%b done=%b halted=%b cnt=%0d, want step=%0d en=%b t=%b done=%b halted=%b cnt=%0d",
                     e.nm, step, step_en, t_state, instr_done, halted, instr_count,
                     e.s, e.en, et, e.d, e.h, e.c);
         end
      end
   end

   // Apply inputs for one cycle, then queue the outputs expected after that edge.
   task automatic cy(input string nm, input logic i_rst, i_run, i_ss, i_req, i_rs, i_h,
                     input logic [2:0] i_ls, input logic [2:0] e_s,
                     input logic e_en, e_d, e_h, input logic [3:0] e_c);
      exp_t e;
      reset = i_rst; run = i_run; single_step = i_ss; step_req = i_req;
      restart = i_rs; halt = i_h; last_step = i_ls;
      @(posedge clk);
      #1;
      e.nm = nm; e.s = e_s; e.en = e_en; e.d = e_d; e.h = e_h; e.c = e_c;
      q.push_back(e);
   endtask

   initial begin
      //  name       rst run ss req rs  h  ls  | step en done hlt cnt
      // Free-run, last_step=3
      cy("rst0",      1, 0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0);
      cy("rst1",      1, 0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0);
      cy("idle",      0, 0, 0, 1, 0, 0, 3,   0, 0, 0, 0, 0);
      cy("fr_t0",     0, 1, 0, 0, 0, 0, 3,   0, 1, 0, 0, 0);
      cy("fr_t1",     0, 1, 0, 0, 0, 0, 3,   1, 1, 0, 0, 0);
      cy("fr_t2",     0, 1, 0, 0, 0, 0, 3,   2, 1, 0, 0, 0);
      cy("fr_t3",     0, 1, 0, 0, 0, 0, 3,   3, 1, 0, 0, 0);
      cy("fr_wrap1",  0, 1, 0, 0, 0, 0, 3,   0, 1, 1, 0, 1);
      cy("fr_t1b",    0, 1, 0, 0, 0, 0, 3,   1, 1, 0, 0, 1);
      cy("fr_t2b",    0, 1, 0, 0, 0, 0, 3,   2, 1, 0, 0, 1);
      cy("fr_t3b",    0, 1, 0, 0, 0, 0, 3,   3, 1, 0, 0, 1);
      cy("fr_wrap2",  0, 1, 0, 0, 0, 0, 3,   0, 1, 1, 0, 2);
      cy("fr_t1c",    0, 1, 0, 0, 0, 0, 3,   1, 1, 0, 0, 2);
      // Single-step, last_step=2
      cy("ss_rst",    1, 0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0);
      cy("ss_idle",   0, 0, 1, 1, 0, 0, 2,   0, 0, 0, 0, 0);
      cy("ss_t0",     0, 1, 1, 0, 0, 0, 2,   0, 1, 0, 0, 0);
      cy("ss_hold0",  0, 1, 1, 0, 0, 0, 2,   0, 1, 0, 0, 0);
      cy("ss_req1",   0, 1, 1, 1, 0, 0, 2,   1, 1, 0, 0, 0);
      cy("ss_hold1",  0, 1, 1, 0, 0, 0, 2,   1, 1, 0, 0, 0);
      cy("ss_hold1b", 0, 1, 1, 0, 0, 0, 2,   1, 1, 0, 0, 0);
      cy("ss_req2",   0, 1, 1, 1, 0, 0, 2,   2, 1, 0, 0, 0);
      cy("ss_hold2",  0, 1, 1, 0, 0, 0, 2,   2, 1, 0, 0, 0);
      cy("ss_wrap",   0, 1, 1, 1, 0, 0, 2,   0, 1, 1, 0, 1);
      cy("ss_after",  0, 1, 1, 0, 0, 0, 2,   0, 1, 0, 0, 1);
      // Restart, last_step=7
      cy("rs_rst",    1, 0, 0, 0, 0, 0, 7,   0, 0, 0, 0, 0);
      cy("rs_t0",     0, 1, 0, 0, 0, 0, 7,   0, 1, 0, 0, 0);
      cy("rs_t1",     0, 1, 0, 0, 0, 0, 7,   1, 1, 0, 0, 0);
      cy("rs_t2",     0, 1, 0, 0, 0, 0, 7,   2, 1, 0, 0, 0);
      cy("rs_t3",     0, 1, 0, 0, 0, 0, 7,   3, 1, 0, 0, 0);
      cy("rs_t4",     0, 1, 0, 0, 0, 0, 7,   4, 1, 0, 0, 0);
      cy("rs_at4",    0, 1, 0, 0, 1, 0, 7,   0, 1, 1, 0, 1);
      cy("rs_t1b",    0, 1, 0, 0, 0, 0, 7,   1, 1, 0, 0, 1);
      cy("rs_sshold", 0, 1, 1, 0, 0, 0, 7,   1, 1, 0, 0, 1);
      cy("rs_req",    0, 1, 1, 1, 1, 0, 7,   0, 1, 1, 0, 2);
      cy("rs_req_af", 0, 1, 1, 0, 0, 0, 7,   0, 1, 0, 0, 2);
      cy("rs_ss_t1",  0, 1, 1, 1, 0, 0, 7,   1, 1, 0, 0, 2);
      cy("rs_noreq",  0, 1, 1, 0, 1, 0, 7,   0, 1, 1, 0, 3);
      cy("rs_nr_af",  0, 1, 1, 0, 0, 0, 7,   0, 1, 0, 0, 3);
      // last_step drops below step: natural wrap 7->0 is not a boundary
      cy("dr_t1",     0, 1, 0, 0, 0, 0, 7,   1, 1, 0, 0, 3);
      cy("dr_t2",     0, 1, 0, 0, 0, 0, 7,   2, 1, 0, 0, 3);
      cy("dr_t3",     0, 1, 0, 0, 0, 0, 1,   3, 1, 0, 0, 3);
      cy("dr_t4",     0, 1, 0, 0, 0, 0, 1,   4, 1, 0, 0, 3);
      cy("dr_t5",     0, 1, 0, 0, 0, 0, 1,   5, 1, 0, 0, 3);
      cy("dr_t6",     0, 1, 0, 0, 0, 0, 1,   6, 1, 0, 0, 3);
      cy("dr_t7",     0, 1, 0, 0, 0, 0, 1,   7, 1, 0, 0, 3);
      cy("dr_wrap",   0, 1, 0, 0, 0, 0, 1,   0, 1, 0, 0, 3);
      cy("dr_t1x",    0, 1, 0, 0, 0, 0, 1,   1, 1, 0, 0, 3);
      cy("dr_bound",  0, 1, 0, 0, 0, 0, 1,   0, 1, 1, 0, 4);
      // Halt at boundary, last_step=5
      cy("h_rst",     1, 0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 0);
      cy("h_t0",      0, 1, 0, 0, 0, 0, 5,   0, 1, 0, 0, 0);
      cy("h_t1",      0, 1, 0, 0, 0, 0, 5,   1, 1, 0, 0, 0);
      cy("h_pulse",   0, 1, 0, 0, 0, 1, 5,   2, 1, 0, 0, 0);
      cy("h_t3",      0, 1, 0, 0, 0, 0, 5,   3, 1, 0, 0, 0);
      cy("h_t4",      0, 1, 0, 0, 0, 0, 5,   4, 1, 0, 0, 0);
      cy("h_t5",      0, 1, 0, 0, 0, 0, 5,   5, 1, 0, 0, 0);
      cy("h_enter",   0, 1, 0, 0, 0, 0, 5,   0, 0, 1, 1, 1);
      cy("h_sticky1", 0, 1, 0, 0, 0, 1, 5,   0, 0, 0, 1, 1);
      cy("h_sticky2", 0, 0, 0, 1, 1, 0, 5,   0, 0, 0, 1, 1);
      cy("h_sticky3", 0, 1, 0, 0, 0, 0, 5,   0, 0, 0, 1, 1);
      // Abort at step 3 keeps pending halt; halt while idle is also remembered
      cy("ab_rst",    1, 0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 0);
      cy("ab_t0",     0, 1, 0, 0, 0, 0, 5,   0, 1, 0, 0, 0);
      cy("ab_t1",     0, 1, 0, 0, 0, 0, 5,   1, 1, 0, 0, 0);
      cy("ab_t2",     0, 1, 0, 0, 0, 1, 5,   2, 1, 0, 0, 0);
      cy("ab_t3",     0, 1, 0, 0, 0, 0, 5,   3, 1, 0, 0, 0);
      cy("ab_abort",  0, 0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 0);
      cy("ab_idle",   0, 0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 0);
      cy("ab_rerun",  0, 1, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0);
      cy("ab_t1b",    0, 1, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0);
      cy("ab_halt",   0, 1, 0, 0, 0, 0, 1,   0, 0, 1, 1, 1);
      cy("id_rst",    1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
      cy("id_halt",   0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0);
      cy("id_t0",     0, 1, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0);
      cy("id_t1",     0, 1, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0);
      cy("id_halted", 0, 1, 0, 0, 0, 0, 1,   0, 0, 1, 1, 1);
      // Reset mid-RUN at step 2
      cy("mr_rst",    1, 0, 0, 0, 0, 0, 7,   0, 0, 0, 0, 0);
      cy("mr_t0",     0, 1, 0, 0, 0, 0, 7,   0, 1, 0, 0, 0);
      cy("mr_t1",     0, 1, 0, 0, 0, 0, 7,   1, 1, 0, 0, 0);
      cy("mr_t2",     0, 1, 0, 0, 0, 0, 7,   2, 1, 0, 0, 0);
      cy("mr_reset",  1, 1, 0, 0, 1, 1, 7,   0, 0, 0, 0, 0);
      // last_step=0 free-run: done every cycle, count saturates at 15
      cy("sat_t0",    0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
      for (int i = 1; i <= 20; i++)
         cy("sat", 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, (i > 15) ? 4'd15 : 4'(i));
      cy("sat_rst",   1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

      repeat (2) @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
